// File: rtl/alarm_set_if.sv
// ============================================================================
// Module      : alarm_set_if
// Description : Key-pulse inputs and committed alarm configuration outputs
//               of the alarm-time setting controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alarm_set_if;
   logic       key_mode;
   logic       key_up;
   logic       key_down;
   logic [4:0] alarm_hour;
   logic [5:0] alarm_min;
   logic       alarm_en;
   logic [1:0] field_sel;
   logic       blink;
   logic       cfg_update;

   // Upstream side: key filters drive pulses, display/comparator read config
   modport master (
      output key_mode, key_up, key_down,
      input  alarm_hour, alarm_min, alarm_en, field_sel, blink, cfg_update
   );

   modport slave (
      input  key_mode, key_up, key_down,
      output alarm_hour, alarm_min, alarm_en, field_sel, blink, cfg_update
   );
endinterface

`default_nettype wire

// File: rtl/alarm_set_ctrl.sv
// ============================================================================
// Module      : alarm_set_ctrl
// Description : Alarm hour/minute/enable editor driven by MODE/UP/DOWN press
//               pulses, with inactivity timeout and field blink phase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_set_ctrl #(
   parameter int TIMEOUT_CYC = 250_000_000,
   parameter int BLINK_HALF  = 12_500_000,
   parameter int RST_HOUR    = 7,
   parameter int RST_MIN     = 0
) (
   input  wire logic  clk,
   input  wire logic  rst_n,
   alarm_set_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HOUR = 2'd1;
   localparam logic [1:0] ST_MIN  = 2'd2;
   localparam logic [1:0] ST_EN   = 2'd3;

   localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);
   localparam logic [4:0]       HOUR_RST = (RST_HOUR >= 0 && RST_HOUR < 24) ? 5'(RST_HOUR) : 5'd0;
   localparam logic [5:0]       MIN_RST  = (RST_MIN >= 0 && RST_MIN < 60) ? 6'(RST_MIN) : 6'd0;

   logic [1:0]       state_q, state_d;
   logic [4:0]       hour_q, hour_d;
   logic [5:0]       min_q, min_d;
   logic             en_q, en_d;
   logic             blink_q, blink_d;
   logic             cfg_update_q, cfg_update_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;

   logic key_any;
   logic up_only;
   logic down_only;
   logic tmo_hit;
   logic leaving_edit;

   assign key_any   = bus.key_mode | bus.key_up | bus.key_down;
   assign up_only   = bus.key_up & ~bus.key_down;
   assign down_only = bus.key_down & ~bus.key_up;
   assign tmo_hit   = (state_q != ST_IDLE) && !key_any && (tmo_cnt_q == TMO_LAST);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.key_mode) state_d = ST_HOUR;
         end
         ST_HOUR: begin
            if (bus.key_mode)  state_d = ST_MIN;
            else if (tmo_hit)  state_d = ST_IDLE;
         end
         ST_MIN: begin
            if (bus.key_mode)  state_d = ST_EN;
            else if (tmo_hit)  state_d = ST_IDLE;
         end
         ST_EN: begin
            if (bus.key_mode)  state_d = ST_IDLE;
            else if (tmo_hit)  state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign leaving_edit = (state_q != ST_IDLE) && (state_d == ST_IDLE);

   // ------------------------------------------------------------------
   // Output / datapath next values
   // ------------------------------------------------------------------
   always_comb begin
      hour_d       = hour_q;
      min_d        = min_q;
      en_d         = en_q;
      blink_d      = blink_q;
      cfg_update_d = leaving_edit;
      tmo_cnt_d    = tmo_cnt_q;
      blk_cnt_d    = blk_cnt_q;

      // MODE has priority: UP/DOWN only edit when no MODE pulse is present
      if (!bus.key_mode) begin
         case (state_q)
            ST_HOUR: begin
               if (up_only)
                  hour_d = (hour_q >= 5'd23) ? 5'd0 : hour_q + 5'd1;
               else if (down_only)
                  hour_d = (hour_q == 5'd0 || hour_q > 5'd23) ? 5'd23 : hour_q - 5'd1;
            end
            ST_MIN: begin
               if (up_only)
                  min_d = (min_q >= 6'd59) ? 6'd0 : min_q + 6'd1;
               else if (down_only)
                  min_d = (min_q == 6'd0 || min_q > 6'd59) ? 6'd59 : min_q - 6'd1;
            end
            ST_EN: begin
               if (up_only || down_only)
                  en_d = ~en_q;
            end
            default: ;
         endcase
      end

      if (state_q == ST_IDLE || key_any || state_d == ST_IDLE)
         tmo_cnt_d = '0;
      else
         tmo_cnt_d = tmo_cnt_q + TMO_W'(1);

      if (state_q == ST_IDLE) begin
         blk_cnt_d = '0;
         blink_d   = bus.key_mode;
      end else if (leaving_edit) begin
         blk_cnt_d = '0;
         blink_d   = 1'b0;
      end else if (key_any) begin
         blk_cnt_d = '0;
         blink_d   = 1'b1;
      end else if (blk_cnt_q >= BLK_LAST) begin
         blk_cnt_d = '0;
         blink_d   = ~blink_q;
      end else begin
         blk_cnt_d = blk_cnt_q + BLK_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hour_q       <= HOUR_RST;
         min_q        <= MIN_RST;
         en_q         <= 1'b0;
         blink_q      <= 1'b0;
         cfg_update_q <= 1'b0;
         tmo_cnt_q    <= '0;
         blk_cnt_q    <= '0;
      end else begin
         hour_q       <= hour_d;
         min_q        <= min_d;
         en_q         <= en_d;
         blink_q      <= blink_d;
         cfg_update_q <= cfg_update_d;
         tmo_cnt_q    <= tmo_cnt_d;
         blk_cnt_q    <= blk_cnt_d;
      end
   end

   assign bus.alarm_hour = hour_q;
   assign bus.alarm_min  = min_q;
   assign bus.alarm_en   = en_q;
   assign bus.field_sel  = state_q;
   assign bus.blink      = blink_q;
   assign bus.cfg_update = cfg_update_q;

endmodule

`default_nettype wire

// File: tb/tb_alarm_set_ctrl.sv
// ============================================================================
// Module      : tb_alarm_set_ctrl
// Description : Directed bench for alarm_set_ctrl with a cycle-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alarm_set_ctrl;
   localparam int TO = 20;
   localparam int BH = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alarm_set_if u_if ();

   alarm_set_ctrl #(
      .TIMEOUT_CYC (TO),
      .BLINK_HALF  (BH),
      .RST_HOUR    (7),
      .RST_MIN     (0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: state index, values, cycle of last activity and of blink phase start
   int m_st, m_hr, m_mn, m_en, m_cfg, m_last, m_phase, m_blk;
   int cyc = 0;
   bit mv  = 1'b0;

   always @(posedge clk) begin
      bit km, ku, kd;
      km = u_if.key_mode;
      ku = u_if.key_up;
      kd = u_if.key_down;
      cyc++;
      if (!rst_n) begin
         m_st = 0; m_hr = 7; m_mn = 0; m_en = 0; m_cfg = 0;
         m_last = cyc; m_phase = cyc;
         mv = 1'b1;
      end else if (mv) begin
         m_cfg = 0;
         if (m_st == 0) begin
            if (km) begin
               m_st = 1; m_last = cyc; m_phase = cyc;
            end
         end else if (km) begin
            m_st = (m_st + 1) % 4;
            if (m_st == 0) m_cfg = 1;
            m_last = cyc; m_phase = cyc;
         end else if (ku || kd) begin
            if (ku != kd) begin
               if (m_st == 1) m_hr = ku ? (m_hr + 1) % 24 : (m_hr + 23) % 24;
               if (m_st == 2) m_mn = ku ? (m_mn + 1) % 60 : (m_mn + 59) % 60;
               if (m_st == 3) m_en = 1 - m_en;
            end
            m_last = cyc; m_phase = cyc;
         end else if (cyc - m_last == TO) begin
            m_st = 0; m_cfg = 1;
         end
      end
      m_blk = (m_st == 0) ? 0 : ((((cyc - m_phase) / BH) % 2) == 0 ? 1 : 0);
      #1;
      if (mv) begin
         chk("m_field_sel", 32'(u_if.field_sel), 32'(m_st));
         chk("m_hour",      32'(u_if.alarm_hour), 32'(m_hr));
         chk("m_min",       32'(u_if.alarm_min), 32'(m_mn));
         chk("m_en",        32'(u_if.alarm_en), 32'(m_en));
         chk("m_blink",     32'(u_if.blink), 32'(m_blk));
         chk("m_cfg_update", 32'(u_if.cfg_update), 32'(m_cfg));
      end
   end

   task automatic pulse(input bit m, input bit u, input bit d);
      @(negedge clk);
      u_if.key_mode = m; u_if.key_up = u; u_if.key_down = d;
      @(negedge clk);
      u_if.key_mode = 1'b0; u_if.key_up = 1'b0; u_if.key_down = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      logic [7:0] pat;
      pat = 8'b1111_0000;
      u_if.key_mode = 1'b0; u_if.key_up = 1'b0; u_if.key_down = 1'b0;

      // Reset values
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_hour", 32'(u_if.alarm_hour), 7);
      chk("rst_min", 32'(u_if.alarm_min), 0);
      chk("rst_en", 32'(u_if.alarm_en), 0);
      chk("rst_field", 32'(u_if.field_sel), 0);
      chk("rst_blink", 32'(u_if.blink), 0);
      chk("rst_cfg", 32'(u_if.cfg_update), 0);

      // Full cycle with wraps
      pulse(1, 0, 0);
      chk("enter_field", 32'(u_if.field_sel), 1);
      chk("enter_blink", 32'(u_if.blink), 1);
      repeat (17) pulse(0, 1, 0);
      chk("hour_wrap_up", 32'(u_if.alarm_hour), 0);
      pulse(0, 0, 1);
      chk("hour_wrap_dn", 32'(u_if.alarm_hour), 23);
      pulse(1, 0, 0);
      repeat (60) pulse(0, 1, 0);
      chk("min_wrap_up", 32'(u_if.alarm_min), 0);
      pulse(0, 0, 1);
      chk("min_wrap_dn", 32'(u_if.alarm_min), 59);
      pulse(1, 0, 0);
      pulse(0, 1, 0);
      chk("en_toggle", 32'(u_if.alarm_en), 1);
      pulse(1, 0, 0);
      chk("exit_field", 32'(u_if.field_sel), 0);
      chk("exit_cfg", 32'(u_if.cfg_update), 1);
      @(negedge clk);
      chk("exit_cfg_one", 32'(u_if.cfg_update), 0);

      // Timeout 20 cycles after MODE edge
      pulse(1, 0, 0);
      repeat (19) @(negedge clk);
      chk("tmo_before", 32'(u_if.field_sel), 1);
      chk("tmo_before_cfg", 32'(u_if.cfg_update), 0);
      @(negedge clk);
      chk("tmo_field", 32'(u_if.field_sel), 0);
      chk("tmo_cfg", 32'(u_if.cfg_update), 1);
      chk("tmo_hour_kept", 32'(u_if.alarm_hour), 23);
      @(negedge clk);
      chk("tmo_cfg_one", 32'(u_if.cfg_update), 0);

      // Key exactly at expiry
      pulse(1, 0, 0);
      repeat (19) @(negedge clk);
      u_if.key_up = 1'b1;
      @(negedge clk);
      u_if.key_up = 1'b0;
      chk("exp_key_field", 32'(u_if.field_sel), 1);
      chk("exp_key_hour", 32'(u_if.alarm_hour), 0);
      repeat (19) @(negedge clk);
      chk("exp_restart_hold", 32'(u_if.field_sel), 1);
      @(negedge clk);
      chk("exp_restart_exit", 32'(u_if.field_sel), 0);
      chk("exp_restart_cfg", 32'(u_if.cfg_update), 1);

      // Simultaneous keys
      pulse(1, 0, 0);
      repeat (2) @(negedge clk);
      pulse(0, 1, 1);
      chk("updn_hour", 32'(u_if.alarm_hour), 0);
      chk("updn_blink", 32'(u_if.blink), 1);
      pulse(1, 1, 0);
      chk("modeup_field", 32'(u_if.field_sel), 2);
      chk("modeup_hour", 32'(u_if.alarm_hour), 0);
      chk("modeup_min", 32'(u_if.alarm_min), 59);

      // Blink phase in SET_MIN
      for (int i = 0; i < 8; i++) begin
         chk("blink_seq", 32'(u_if.blink), 32'(pat[7-i]));
         @(negedge clk);
      end
      repeat (5) @(negedge clk);
      chk("blink_low_mid", 32'(u_if.blink), 0);
      pulse(0, 1, 0);
      chk("blink_restart", 32'(u_if.blink), 1);
      chk("blink_key_min", 32'(u_if.alarm_min), 0);
      pulse(1, 0, 0);
      pulse(1, 0, 0);
      chk("second_exit_cfg", 32'(u_if.cfg_update), 1);

      // UP/DOWN ignored in IDLE
      pulse(0, 1, 0);
      pulse(0, 0, 1);
      chk("idle_hour", 32'(u_if.alarm_hour), 0);
      chk("idle_min", 32'(u_if.alarm_min), 0);
      chk("idle_en", 32'(u_if.alarm_en), 1);
      chk("idle_field", 32'(u_if.field_sel), 0);
      chk("idle_blink", 32'(u_if.blink), 0);

      // Reset mid-edit
      pulse(1, 0, 0);
      pulse(0, 1, 0);
      chk("pre_rst_hour", 32'(u_if.alarm_hour), 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mrst_hour", 32'(u_if.alarm_hour), 7);
      chk("mrst_min", 32'(u_if.alarm_min), 0);
      chk("mrst_en", 32'(u_if.alarm_en), 0);
      chk("mrst_field", 32'(u_if.field_sel), 0);
      chk("mrst_blink", 32'(u_if.blink), 0);
      chk("mrst_cfg", 32'(u_if.cfg_update), 0);
      repeat (3) begin
         @(negedge clk);
         chk("mrst_no_cfg", 32'(u_if.cfg_update), 0);
      end

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire
